// File: rtl/sparse_weight_packer_int8.sv
// Sparse int8 weight packer: drops zero weights from a dense stream and writes
// surviving (index, value) pairs two per word into the packed weight store.
module sparse_weight_packer_int8 #(
    parameter int INDEX_WIDTH = 12,
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [15:0]            vec_len,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr,
    output logic [INDEX_WIDTH-1:0] wr_idx0,
    output logic [INDEX_WIDTH-1:0] wr_idx1,
    output logic [DATA_WIDTH-1:0]  wr_val0,
    output logic [DATA_WIDTH-1:0]  wr_val1,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            nnz_pairs,
    output logic                   tail_odd,
    output logic [INDEX_WIDTH-1:0] tail_idx,
    output logic                   error
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_FLUSH   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(1 << INDEX_WIDTH);

    state_t                 state_q, state_d;
    logic [15:0]            vec_len_q, vec_len_d;
    logic [15:0]            elem_idx_q, elem_idx_d;
    logic                   hold_valid_q, hold_valid_d;
    logic [INDEX_WIDTH-1:0] hold_idx_q, hold_idx_d;
    logic [DATA_WIDTH-1:0]  hold_val_q, hold_val_d;
    logic [ADDR_WIDTH:0]    pair_cnt_q, pair_cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [INDEX_WIDTH-1:0] wr_idx0_q, wr_idx0_d, wr_idx1_q, wr_idx1_d;
    logic [DATA_WIDTH-1:0]  wr_val0_q, wr_val0_d, wr_val1_q, wr_val1_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tail_odd_q, tail_odd_d;
    logic [INDEX_WIDTH-1:0] tail_idx_q, tail_idx_d;
    logic                   error_q, error_d;

    logic                   accept;
    logic                   wr_req;
    logic [INDEX_WIDTH-1:0] req_idx0, req_idx1;
    logic [DATA_WIDTH-1:0]  req_val0, req_val1;

    // Handshake: an element transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready depends only on state, never on in_valid.
    assign in_ready = (state_q == S_COLLECT);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d      = state_q;
        vec_len_d    = vec_len_q;
        elem_idx_d   = elem_idx_q;
        hold_valid_d = hold_valid_q;
        hold_idx_d   = hold_idx_q;
        hold_val_d   = hold_val_q;
        pair_cnt_d   = pair_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_idx0_d    = wr_idx0_q;
        wr_idx1_d    = wr_idx1_q;
        wr_val0_d    = wr_val0_q;
        wr_val1_d    = wr_val1_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        tail_odd_d   = tail_odd_q;
        tail_idx_d   = tail_idx_q;
        error_d      = error_q;
        wr_req       = 1'b0;
        req_idx0     = hold_idx_q;
        req_idx1     = '0;
        req_val0     = hold_val_q;
        req_val1     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vec_len_d    = vec_len;
                    elem_idx_d   = '0;
                    wr_addr_d    = '0;
                    hold_valid_d = 1'b0;
                    pair_cnt_d   = '0;
                    tail_odd_d   = 1'b0;
                    tail_idx_d   = '0;
                    error_d      = 1'b0;
                    busy_d       = 1'b1;
                    if (vec_len == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, vec_len} > MAX_LEN) begin
                        error_d = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    elem_idx_d = elem_idx_q + 16'd1;
                    if (in_data != '0) begin
                        if (!hold_valid_q) begin
                            hold_valid_d = 1'b1;
                            hold_idx_d   = elem_idx_q[INDEX_WIDTH-1:0];
                            hold_val_d   = in_data;
                        end else begin
                            hold_valid_d = 1'b0;
                            wr_req       = 1'b1;
                            req_idx1     = elem_idx_q[INDEX_WIDTH-1:0];
                            req_val1     = in_data;
                        end
                    end
                    if (elem_idx_q + 16'd1 == vec_len_q) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (hold_valid_q) begin
                    hold_valid_d = 1'b0;
                    wr_req       = 1'b1;
                    tail_odd_d   = 1'b1;
                    tail_idx_d   = hold_idx_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The MSB of pair_cnt marks a full store; further pairs are dropped.
        if (wr_req) begin
            if (pair_cnt_q[ADDR_WIDTH]) begin
                error_d = 1'b1;
            end else begin
                wr_en_d    = 1'b1;
                wr_addr_d  = pair_cnt_q[ADDR_WIDTH-1:0];
                wr_idx0_d  = req_idx0;
                wr_idx1_d  = req_idx1;
                wr_val0_d  = req_val0;
                wr_val1_d  = req_val1;
                pair_cnt_d = pair_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            vec_len_q    <= '0;
            elem_idx_q   <= '0;
            hold_valid_q <= 1'b0;
            hold_idx_q   <= '0;
            hold_val_q   <= '0;
            pair_cnt_q   <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_idx0_q    <= '0;
            wr_idx1_q    <= '0;
            wr_val0_q    <= '0;
            wr_val1_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tail_odd_q   <= 1'b0;
            tail_idx_q   <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_len_q    <= vec_len_d;
            elem_idx_q   <= elem_idx_d;
            hold_valid_q <= hold_valid_d;
            hold_idx_q   <= hold_idx_d;
            hold_val_q   <= hold_val_d;
            pair_cnt_q   <= pair_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_idx0_q    <= wr_idx0_d;
            wr_idx1_q    <= wr_idx1_d;
            wr_val0_q    <= wr_val0_d;
            wr_val1_q    <= wr_val1_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tail_odd_q   <= tail_odd_d;
            tail_idx_q   <= tail_idx_d;
            error_q      <= error_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_idx0   = wr_idx0_q;
    assign wr_idx1   = wr_idx1_q;
    assign wr_val0   = wr_val0_q;
    assign wr_val1   = wr_val1_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign nnz_pairs = 16'(pair_cnt_q);
    assign tail_odd  = tail_odd_q;
    assign tail_idx  = tail_idx_q;
    assign error     = error_q;

endmodule
